// File: rtl/gaa_regs_pkg.sv
// rtl/gaa_regs_pkg.sv - register map, bit positions and reset values for gaa_avalon_regs
package gaa_regs_pkg;

  typedef enum logic [2:0] {
    ADDR_CTRL     = 3'd0,
    ADDR_STATUS   = 3'd1,
    ADDR_CONFIG   = 3'd2,
    ADDR_SEED     = 3'd3,
    ADDR_RESULT   = 3'd4,
    ADDR_IRQ_EN   = 3'd5,
    ADDR_IRQ_STAT = 3'd6,
    ADDR_RSVD     = 3'd7
  } addr_e;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_FULL_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_UDF_BIT   = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam int IRQ_DONE_BIT   = 0;
  localparam int IRQ_THRESH_BIT = 1;

  localparam logic [23:0] CONFIG_RST   = 24'h0;
  localparam logic [31:0] SEED_RST     = 32'h0;
  localparam logic [1:0]  IRQ_EN_RST   = 2'b00;
  localparam logic [1:0]  IRQ_STAT_RST = 2'b00;

endpackage

// File: rtl/gaa_result_fifo.sv
// rtl/gaa_result_fifo.sv - synchronous result FIFO with flush, registered pop data and error events
module gaa_result_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf_evt,
  output logic              udf_evt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  // Flush dominates everything in its cycle, including error events.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign ovf_evt = push && full && !flush;
  assign udf_evt = pop && empty && !flush;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (pop) rd_data <= pop_ok ? mem[rptr] : '0;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + PTR_W'(1);
        if (pop_ok)  rptr <= rptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/gaa_avalon_regs.sv
// rtl/gaa_avalon_regs.sv - Avalon-MM register agent for the GA core: decode, registers, result FIFO, irq
module gaa_avalon_regs
  import gaa_regs_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              irq,
  output logic              core_start,
  output logic [15:0]       core_pop_size,
  output logic [DATA_W-1:0] core_seed,
  input  logic              core_busy,
  input  logic              core_done,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              res_ready
);

  addr_e             addr;
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              pop;
  logic              stat_w1c;

  logic [23:0]       cfg_q;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        irq_en_q;
  logic [1:0]        irq_stat_q;
  logic [1:0]        irq_stat_nxt;
  logic              ovf_q;
  logic              udf_q;

  logic [DATA_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf_evt;
  logic              udf_evt;
  logic              thresh_hit;

  logic [DATA_W-1:0] reg_rd;
  logic [DATA_W-1:0] reg_rd_q;
  logic              res_sel_q;
  logic [31:0]       status;

  assign addr     = addr_e'(address);
  assign wr_en    = chipselect && write;
  assign rd_en    = chipselect && read;
  assign flush    = wr_en && (addr == ADDR_CTRL) && writedata[CTRL_FLUSH_BIT];
  assign pop      = rd_en && (addr == ADDR_RESULT);
  assign stat_w1c = wr_en && (addr == ADDR_IRQ_STAT);

  gaa_result_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (res_valid),
    .push_data (res_data),
    .pop       (pop),
    .flush     (flush),
    .rd_data   (fifo_rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf_evt   (ovf_evt),
    .udf_evt   (udf_evt)
  );

  assign res_ready     = !full;
  assign core_pop_size = cfg_q[15:0];
  assign core_seed     = seed_q;
  assign thresh_hit    = (cfg_q[23:16] != 8'd0) && (32'(count) >= 32'(cfg_q[23:16]));

  // Done pulse beats a same-cycle clear; threshold clear lands first and re-sets next cycle.
  always_comb begin
    irq_stat_nxt = irq_stat_q;
    if (stat_w1c) irq_stat_nxt = irq_stat_q & ~writedata[1:0];
    if (core_done) irq_stat_nxt[IRQ_DONE_BIT] = 1'b1;
    if (thresh_hit && !(stat_w1c && writedata[IRQ_THRESH_BIT]))
      irq_stat_nxt[IRQ_THRESH_BIT] = 1'b1;
  end

  always_comb begin
    status = 32'h0;
    status[ST_BUSY_BIT]  = core_busy;
    status[ST_EMPTY_BIT] = empty;
    status[ST_FULL_BIT]  = full;
    status[ST_OVF_BIT]   = ovf_q;
    status[ST_UDF_BIT]   = udf_q;
    status[ST_COUNT_LSB +: 8] = 8'(count);
  end

  always_comb begin
    reg_rd = '0;
    case (addr)
      ADDR_STATUS:   reg_rd = DATA_W'(status);
      ADDR_CONFIG:   reg_rd = DATA_W'(cfg_q);
      ADDR_SEED:     reg_rd = seed_q;
      ADDR_IRQ_EN:   reg_rd = DATA_W'(irq_en_q);
      ADDR_IRQ_STAT: reg_rd = DATA_W'(irq_stat_q);
      default:       reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q      <= CONFIG_RST;
      seed_q     <= DATA_W'(SEED_RST);
      irq_en_q   <= IRQ_EN_RST;
      irq_stat_q <= IRQ_STAT_RST;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      core_start <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_en && addr == ADDR_CONFIG) cfg_q    <= writedata[23:0];
      if (wr_en && addr == ADDR_SEED)   seed_q   <= writedata;
      if (wr_en && addr == ADDR_IRQ_EN) irq_en_q <= writedata[1:0];
      irq_stat_q <= irq_stat_nxt;
      ovf_q      <= flush ? 1'b0 : (ovf_q || ovf_evt);
      udf_q      <= flush ? 1'b0 : (udf_q || udf_evt);
      core_start <= wr_en && (addr == ADDR_CTRL) && writedata[CTRL_START_BIT];
      irq        <= |(irq_stat_q & irq_en_q);
    end
  end

  // RESULT data is already registered in the FIFO, so readdata selects between two registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdatavalid <= 1'b0;
      reg_rd_q      <= '0;
      res_sel_q     <= 1'b0;
    end else begin
      readdatavalid <= rd_en;
      if (rd_en) begin
        res_sel_q <= (addr == ADDR_RESULT);
        if (addr != ADDR_RESULT) reg_rd_q <= reg_rd;
      end
    end
  end

  assign readdata = res_sel_q ? fifo_rd_data : reg_rd_q;

endmodule

// File: tb/tb_gaa_avalon_regs.sv
// tb/tb_gaa_avalon_regs.sv - directed self-checking bench for gaa_avalon_regs
module tb_gaa_avalon_regs;
  import gaa_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        irq;
  logic        core_start;
  logic [15:0] core_pop_size;
  logic [31:0] core_seed;
  logic        core_busy;
  logic        core_done;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  gaa_avalon_regs #(.DATA_W(32), .FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq),
    .core_start    (core_start),
    .core_pop_size (core_pop_size),
    .core_seed     (core_seed),
    .core_busy     (core_busy),
    .core_done     (core_done),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = wd;
    tick;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick;
    chipselect = 1'b0; read = 1'b0;
    check("rdvalid", {31'b0, readdatavalid}, 32'h1);
    rd = readdata;
  endtask

  task automatic push(input logic [31:0] pd);
    res_valid = 1'b1; res_data = pd;
    tick;
    res_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0;
    writedata = '0; core_busy = 1'b0; core_done = 1'b0; res_valid = 1'b0; res_data = '0;
    repeat (2) tick;
    check("rst_readdata", readdata, 32'h0);
    check("rst_rdvalid", {31'b0, readdatavalid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_start", {31'b0, core_start}, 32'h0);
    check("rst_res_ready", {31'b0, res_ready}, 32'h1);
    reset = 1'b0;
    tick;

    // Reset asserted in the same cycle as a read
    bus_write(ADDR_SEED, 32'h0000_1234);
    bus_read(ADDR_SEED, d);
    check("seed_pre", d, 32'h0000_1234);
    chipselect = 1'b1; read = 1'b1; address = ADDR_SEED; reset = 1'b1;
    tick;
    check("midrst_rdvalid", {31'b0, readdatavalid}, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_seed", core_seed, 32'h0);
    check("midrst_res_ready", {31'b0, res_ready}, 32'h1);
    chipselect = 1'b0; read = 1'b0; reset = 1'b0;
    tick;
    bus_read(ADDR_STATUS, d);
    check("status_after_rst", d, 32'h0000_0002);
    core_busy = 1'b1;
    bus_read(ADDR_STATUS, d);
    check("status_busy", d, 32'h0000_0003);
    core_busy = 1'b0;
    tick;
    check("rdvalid_idle", {31'b0, readdatavalid}, 32'h0);
    bus_read(ADDR_RSVD, d);
    check("rsvd_read", d, 32'h0);

    // Configuration
    bus_write(ADDR_CONFIG, 32'h0004_0100);
    bus_write(ADDR_SEED, 32'hDEAD_BEEF);
    check("pop_size", {16'b0, core_pop_size}, 32'h0000_0100);
    check("core_seed", core_seed, 32'hDEAD_BEEF);
    bus_read(ADDR_CONFIG, d);
    check("config_rb", d, 32'h0004_0100);
    bus_read(ADDR_SEED, d);
    check("seed_rb", d, 32'hDEAD_BEEF);
    bus_read(ADDR_CTRL, d);
    check("ctrl_read", d, 32'h0);

    // Start pulses
    check("start_idle", {31'b0, core_start}, 32'h0);
    bus_write(ADDR_CTRL, 32'h1);
    check("start_pulse", {31'b0, core_start}, 32'h1);
    tick;
    check("start_end", {31'b0, core_start}, 32'h0);
    chipselect = 1'b1; write = 1'b1; address = ADDR_CTRL; writedata = 32'h1;
    tick;
    check("start_b2b_1", {31'b0, core_start}, 32'h1);
    tick;
    chipselect = 1'b0; write = 1'b0;
    check("start_b2b_2", {31'b0, core_start}, 32'h1);
    tick;
    check("start_b2b_end", {31'b0, core_start}, 32'h0);

    // Fill, overflow, drain, underflow, flush
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    check("full_res_ready", {31'b0, res_ready}, 32'h0);
    bus_read(ADDR_STATUS, d);
    check("status_full", d, 32'h0000_1004);
    push(32'h1FF);
    bus_read(ADDR_STATUS, d);
    check("status_ovf", d, 32'h0000_100C);
    check("irq_masked", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_RESULT, d);
      check("drain", d, 32'h100 + 32'(i));
    end
    bus_read(ADDR_RESULT, d);
    check("underflow_data", d, 32'h0);
    bus_read(ADDR_STATUS, d);
    check("status_udf", d, 32'h0000_001A);
    bus_write(ADDR_CTRL, 32'h2);
    bus_read(ADDR_STATUS, d);
    check("status_flushed", d, 32'h0000_0002);

    // Interrupts
    bus_write(ADDR_IRQ_STAT, 32'h3);
    bus_read(ADDR_IRQ_STAT, d);
    check("irqstat_clear", d, 32'h0);
    bus_write(ADDR_IRQ_EN, 32'h3);
    bus_read(ADDR_IRQ_EN, d);
    check("irqen_rb", d, 32'h3);
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
    tick;
    tick;
    check("irq_thresh", {31'b0, irq}, 32'h1);
    bus_read(ADDR_IRQ_STAT, d);
    check("irqstat_thresh", d, 32'h2);
    bus_write(ADDR_IRQ_STAT, 32'h2);
    bus_read(ADDR_IRQ_STAT, d);
    check("irqstat_w1c", d, 32'h0);
    check("irq_dropped", {31'b0, irq}, 32'h0);
    bus_read(ADDR_IRQ_STAT, d);
    check("irqstat_reset", d, 32'h2);
    check("irq_again", {31'b0, irq}, 32'h1);
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
    bus_read(ADDR_IRQ_STAT, d);
    check("irqstat_done", d, 32'h3);
    chipselect = 1'b1; write = 1'b1; address = ADDR_IRQ_STAT; writedata = 32'h1; core_done = 1'b1;
    tick;
    chipselect = 1'b0; write = 1'b0; core_done = 1'b0;
    bus_read(ADDR_IRQ_STAT, d);
    check("done_beats_w1c", d, 32'h3);
    bus_write(ADDR_IRQ_STAT, 32'h1);
    bus_read(ADDR_IRQ_STAT, d);
    check("done_w1c", d, 32'h2);

    // Simultaneous push and pop at count 5
    push(32'h204);
    bus_read(ADDR_STATUS, d);
    check("status_cnt5", d, 32'h0000_0500);
    res_valid = 1'b1; res_data = 32'h205;
    chipselect = 1'b1; read = 1'b1; address = ADDR_RESULT;
    tick;
    res_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    check("pushpop_rdvalid", {31'b0, readdatavalid}, 32'h1);
    check("pushpop_data", readdata, 32'h200);
    bus_read(ADDR_STATUS, d);
    check("status_still5", d, 32'h0000_0500);
    for (int i = 1; i < 6; i++) begin
      bus_read(ADDR_RESULT, d);
      check("order", d, 32'h200 + 32'(i));
    end
    bus_read(ADDR_STATUS, d);
    check("status_end", d, 32'h0000_0002);
    check("res_ready_end", {31'b0, res_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
